// File: rtl/acc_cpu_core.sv
// Accumulator CPU core: parametrised accumulator, on-chip data memory, carry/zero flags,
// valid/ready instruction port and a one-cycle done pulse per retired instruction.
module acc_cpu_core #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [3:0]        opcode,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] acc_out,
  output logic              carry,
  output logic              zero,
  output logic              done,
  output logic [1:0]        dbg_state_o
);

  // Handshake: an instruction transfers on the rising edge where instr_valid && instr_ready;
  // instr_ready is high only in IDLE, and opcode/addr/imm are captured on that edge.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MEM  = 2'd1,
    S_EXEC = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_LOAD  = 4'h3;
  localparam logic [3:0] OP_ADDM  = 4'h4;
  localparam logic [3:0] OP_AND   = 4'h5;
  localparam logic [3:0] OP_OR    = 4'h6;
  localparam logic [3:0] OP_XOR   = 4'h7;
  localparam logic [3:0] OP_NOT   = 4'h8;
  localparam logic [3:0] OP_SHL   = 4'h9;
  localparam logic [3:0] OP_SHR   = 4'hA;
  localparam logic [3:0] OP_LDI   = 4'hB;

  state_t              state_q, state_d;
  logic [3:0]          opc_q, opc_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   imm_q, imm_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic                carry_q, carry_d;
  logic                zero_q, zero_d;
  logic [DATA_W-1:0]   rd_q;
  logic [DATA_W-1:0]   mem [2**ADDR_W];

  logic                accept;
  logic [DATA_W-1:0]   add_b;
  logic [DATA_W:0]     add_ext;
  logic [DATA_W:0]     sub_ext;
  logic [DATA_W-1:0]   alu_res;
  logic                alu_c;
  logic                wr_acc;
  logic                wr_c;

  assign accept      = instr_valid && (state_q == S_IDLE);
  assign instr_ready = (state_q == S_IDLE);
  assign done        = (state_q == S_DONE);
  assign acc_out     = acc_q;
  assign carry       = carry_q;
  assign zero        = zero_q;
  assign dbg_state_o = state_q;

  // ADDM shares the adder with ADD; its operand comes from the registered memory read.
  assign add_b   = (opc_q == OP_ADDM) ? rd_q : imm_q;
  assign add_ext = {1'b0, acc_q} + {1'b0, add_b};
  assign sub_ext = {1'b0, acc_q} - {1'b0, imm_q};

  always_comb begin
    alu_res = acc_q;
    alu_c   = carry_q;
    wr_acc  = 1'b0;
    wr_c    = 1'b0;
    case (opc_q)
      OP_ADD, OP_ADDM: begin alu_res = add_ext[DATA_W-1:0]; alu_c = add_ext[DATA_W]; wr_acc = 1'b1; wr_c = 1'b1; end
      OP_SUB:  begin alu_res = sub_ext[DATA_W-1:0]; alu_c = sub_ext[DATA_W]; wr_acc = 1'b1; wr_c = 1'b1; end
      OP_LOAD: begin alu_res = rd_q;          wr_acc = 1'b1; end
      OP_AND:  begin alu_res = acc_q & imm_q; wr_acc = 1'b1; end
      OP_OR:   begin alu_res = acc_q | imm_q; wr_acc = 1'b1; end
      OP_XOR:  begin alu_res = acc_q ^ imm_q; wr_acc = 1'b1; end
      OP_NOT:  begin alu_res = ~acc_q;        wr_acc = 1'b1; end
      OP_SHL:  begin alu_res = {acc_q[DATA_W-2:0], 1'b0}; alu_c = acc_q[DATA_W-1]; wr_acc = 1'b1; wr_c = 1'b1; end
      OP_SHR:  begin alu_res = {1'b0, acc_q[DATA_W-1:1]}; alu_c = acc_q[0];        wr_acc = 1'b1; wr_c = 1'b1; end
      OP_LDI:  begin alu_res = imm_q;         wr_acc = 1'b1; end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    opc_d   = opc_q;
    addr_d  = addr_q;
    imm_d   = imm_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          opc_d   = opcode;
          addr_d  = addr;
          imm_d   = imm;
          state_d = (opcode == OP_LOAD || opcode == OP_ADDM) ? S_MEM : S_EXEC;
        end
      end
      S_MEM:  state_d = S_EXEC;
      S_EXEC: begin
        state_d = S_DONE;
        if (wr_acc) begin
          acc_d  = alu_res;
          zero_d = (alu_res == '0);
        end
        if (wr_c) carry_d = alu_c;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      opc_q   <= '0;
      addr_q  <= '0;
      imm_q   <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
      addr_q  <= addr_d;
      imm_q   <= imm_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
    end
  end

  // Memory contents survive reset; STORE commits on the EXEC edge, so a later MEM read sees it.
  always_ff @(posedge clk) begin
    if (state_q == S_EXEC && opc_q == OP_STORE) mem[addr_q] <= acc_q;
    if (state_q == S_MEM) rd_q <= mem[addr_q];
  end

endmodule

// File: tb/tb_acc_cpu_core.sv
// Bench for acc_cpu_core: a 4-bit and an 8-bit instance run the same instruction stream
// in lockstep against a width-aware reference model and expected-result queues.
module tb_acc_cpu_core;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid;
  logic [3:0] opcode;
  logic [5:0] addr;
  logic [7:0] imm;

  logic       rdy4, c4, z4, done4;
  logic [3:0] acc4;
  logic [1:0] st4;
  logic       rdy8, c8, z8, done8;
  logic [7:0] acc8;
  logic [1:0] st8;

  int n_tests = 0;
  int n_fail  = 0;

  logic [9:0] exp4_q[$];
  logic [9:0] exp8_q[$];
  int m_acc [2];
  int m_c   [2];
  int m_z   [2];
  int m_mem [2][64];

  always #5 clk = ~clk;

  acc_cpu_core #(.DATA_W(4), .ADDR_W(4)) dut4 (
    .clk(clk), .rst(rst), .instr_valid(valid), .instr_ready(rdy4), .opcode(opcode),
    .addr(addr[3:0]), .imm(imm[3:0]), .acc_out(acc4), .carry(c4), .zero(z4),
    .done(done4), .dbg_state_o(st4)
  );

  acc_cpu_core #(.DATA_W(8), .ADDR_W(6)) dut8 (
    .clk(clk), .rst(rst), .instr_valid(valid), .instr_ready(rdy8), .opcode(opcode),
    .addr(addr), .imm(imm), .acc_out(acc8), .carry(c8), .zero(z8),
    .done(done8), .dbg_state_o(st8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_acc[k] = 0; m_c[k] = 0; m_z[k] = 0;
    end
  endtask

  task automatic model_push(input logic [3:0] op, input logic [5:0] a, input logic [7:0] im);
    for (int k = 0; k < 2; k++) begin
      int w, mask, ai, iv, acc, s;
      w    = (k == 1) ? 8 : 4;
      mask = (1 << w) - 1;
      ai   = (k == 1) ? int'(a) : int'(a) & 15;
      iv   = int'(im) & mask;
      acc  = m_acc[k];
      case (op)
        4'h0: begin s = acc + iv; m_acc[k] = s & mask; m_c[k] = (s >> w) & 1; end
        4'h1: begin m_c[k] = (acc < iv) ? 1 : 0; m_acc[k] = (acc - iv) & mask; end
        4'h2: m_mem[k][ai] = acc;
        4'h3: m_acc[k] = m_mem[k][ai];
        4'h4: begin s = acc + m_mem[k][ai]; m_acc[k] = s & mask; m_c[k] = (s >> w) & 1; end
        4'h5: m_acc[k] = acc & iv;
        4'h6: m_acc[k] = acc | iv;
        4'h7: m_acc[k] = acc ^ iv;
        4'h8: m_acc[k] = (~acc) & mask;
        4'h9: begin m_c[k] = (acc >> (w - 1)) & 1; m_acc[k] = (acc << 1) & mask; end
        4'hA: begin m_c[k] = acc & 1; m_acc[k] = acc >> 1; end
        4'hB: m_acc[k] = iv;
        default: ;
      endcase
      if (op != 4'h2 && op < 4'hC) m_z[k] = (m_acc[k] == 0) ? 1 : 0;
      if (k == 0) exp4_q.push_back({8'(m_acc[k]), 1'(m_c[k]), 1'(m_z[k])});
      else        exp8_q.push_back({8'(m_acc[k]), 1'(m_c[k]), 1'(m_z[k])});
    end
  endtask

  // Scoreboard: every retired instruction pops one expected result per instance.
  always @(negedge clk) begin
    if (!rst && (done4 || done8)) begin
      logic [9:0] e4, e8;
      check("done_pair", done8, done4);
      if (exp4_q.size() == 0 || exp8_q.size() == 0) begin
        check("spurious_done", 1, 0);
      end else begin
        e4 = exp4_q.pop_front();
        e8 = exp8_q.pop_front();
        check("acc4", acc4, e4[5:2]);
        check("carry4", c4, e4[1]);
        check("zero4", z4, e4[0]);
        check("acc8", acc8, e8[9:2]);
        check("carry8", c8, e8[1]);
        check("zero8", z8, e8[0]);
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [5:0] a, input logic [7:0] im);
    int n;
    n = 0;
    @(negedge clk);
    while (!rdy4 && n < 20) begin @(negedge clk); n++; end
    check("ready_wait", (n < 20) ? 1 : 0, 1);
    valid = 1'b1; opcode = op; addr = a; imm = im;
    model_push(op, a, im);
    @(posedge clk); #1;
    valid = 1'b0; opcode = 4'($urandom); imm = 8'($urandom);
    n = 0;
    while (!done4 && n < 10) begin @(negedge clk); n++; end
    check("latency", n, (op == 4'h3 || op == 4'h4) ? 3 : 2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen_done;
    rst = 1'b1; valid = 1'b0; opcode = '0; addr = '0; imm = '0;
    model_reset();
    #1;
    check("rst_acc", acc4, 0);
    check("rst_carry", c4, 0);
    check("rst_zero", z4, 0);
    check("rst_done", done4, 0);
    check("rst_ready", rdy4, 1);
    check("rst_state", st4, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Wrap on both widths
    issue(4'hB, 0, 8'h0F);
    issue(4'h0, 0, 8'h01);
    check("wrap_acc4", acc4, 4'h0); check("wrap_c4", c4, 1); check("wrap_z4", z4, 1);
    check("wrap_acc8", acc8, 8'h10); check("wrap_c8", c8, 0);
    issue(4'hB, 0, 8'hFF);
    issue(4'h0, 0, 8'h01);
    check("wrap8_acc", acc8, 8'h00); check("wrap8_c", c8, 1); check("wrap8_z", z8, 1);

    // Memory round trip
    issue(4'hB, 0, 8'h06);
    issue(4'h2, 5, 8'h00);
    issue(4'hB, 0, 8'h00);
    issue(4'h3, 5, 8'h00);
    check("load_acc4", acc4, 4'h6); check("load_z4", z4, 0);
    issue(4'h4, 5, 8'h00);
    check("addm_acc4", acc4, 4'hC); check("addm_c4", c4, 0);

    // Borrow and logic
    issue(4'hB, 0, 8'h02);
    issue(4'h1, 0, 8'h03);
    check("sub_acc4", acc4, 4'hF); check("sub_c4", c4, 1);
    issue(4'h7, 0, 8'h0F);
    check("xor_acc4", acc4, 4'h0); check("xor_z4", z4, 1); check("xor_c4", c4, 1);

    // Shifts and NOP
    issue(4'hB, 0, 8'h09);
    issue(4'h9, 0, 8'h00);
    check("shl_acc4", acc4, 4'h2); check("shl_c4", c4, 1);
    issue(4'hA, 0, 8'h00);
    check("shr_acc4", acc4, 4'h1); check("shr_c4", c4, 0);
    issue(4'hE, 0, 8'h00);
    check("nop_acc4", acc4, 4'h1); check("nop_c4", c4, 0);

    // Async reset in the middle of a LOAD
    issue(4'hB, 0, 8'h0F);
    issue(4'h0, 0, 8'h02);
    @(negedge clk);
    valid = 1'b1; opcode = 4'h3; addr = 6'd5;
    @(posedge clk); #1;
    valid = 1'b0;
    check("mid_load_state", st4, 1);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    #1;
    check("arst_acc4", acc4, 0); check("arst_c4", c4, 0); check("arst_z4", z4, 0);
    check("arst_done4", done4, 0); check("arst_acc8", acc8, 0);
    @(negedge clk);
    rst = 1'b0;
    check("arst_ready", rdy4, 1);
    seen_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done4 || done8) seen_done = 1'b1;
    end
    check("arst_no_done", seen_done, 0);

    // Random stream, memory words 0..7 written first
    for (int i = 0; i < 8; i++) begin
      issue(4'hB, 0, 8'($urandom));
      issue(4'h2, 6'(i), 0);
    end
    for (int i = 0; i < 40; i++)
      issue(4'($urandom_range(0, 15)), 6'($urandom_range(0, 7)), 8'($urandom));

    // valid held high with changing fields: only values seen while ready retire
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      valid  = 1'b1;
      opcode = 4'($urandom_range(0, 15));
      addr   = 6'($urandom_range(0, 7));
      imm    = 8'($urandom);
      if (rdy4) model_push(opcode, addr, imm);
    end
    @(posedge clk); #1;
    valid = 1'b0;
    repeat (8) @(negedge clk);

    check("q4_empty", exp4_q.size(), 0);
    check("q8_empty", exp8_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
